trinity_genome_mutator: RTL
===========================

Name: trinity_genome_mutator

Overview:
- Downstream consumer of the trinity gene sequencer's ternary mutation stream.
- Applies each incoming mutation trit to one position of an on-chip ternary genome register file, using saturating ternary addition.
- After each full pass over the genome (one generation), streams the genome out over a valid/ready port.
- Drives the sequencer's enable, so the mutation source stalls while readout is in progress.

Parameters:
- GENOME_LEN, 16, number of trits in the genome (minimum 2).
- IDX_W, $clog2(GENOME_LEN), width of the position/index fields.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- run  in  1  permits mutation consumption.
- seq_enable  out  1  enable to the upstream sequencer.
- trit_valid  in  1  mutation_trit is valid this cycle (registered copy of seq_enable, 1-cycle latency).
- mutation_trit  in  2  ternary mutation: 00=0, 01=+1, 10=-1, 11=invalid.
- gene_valid  out  1  readout beat valid.
- gene_ready  in  1  downstream accepts the readout beat.
- gene_out  out  2  gene trit at gene_idx.
- gene_idx  out  IDX_W  readout position.
- gen_count  out  CNT_W  completed generations, saturating.
- mut_count  out  CNT_W  nonzero valid trits applied, saturating.
- err_count  out  CNT_W  invalid trits plus skid overflows, saturating.
- err_flag  out  1  sticky; set on any error; cleared only by reset.

Behaviour:
- Reset (rst_n=0 sampled at posedge) clears the following, regardless of state or any transfer in progress:
  - all genome trits to 00;
  - ptr and dump_idx to 0;
  - state to APPLY;
  - skid to empty;
  - all counters and err_flag to 0.
  - Outputs during and after reset: seq_enable=0, gene_valid=0, gene_out=00, gene_idx=0.
- seq_enable is combinational: run && state==APPLY && !skid_valid.
- FSM states: APPLY and DUMP.
- APPLY, accept rule: a trit is accepted when trit_valid=1, or when the skid is full (the skid has priority and is applied first).
- APPLY, on accept:
  - genome[ptr] <= sat(genome[ptr] + trit), with the result clamped to {-1,0,+1};
  - +1 plus +1 stays +1; -1 plus -1 stays -1; opposite signs give 0.
- APPLY, trit 11: treated as 0 (genome unchanged); err_count++ and err_flag is set; ptr still advances.
- APPLY, mut_count: increments on each accepted 01 or 10.
- APPLY, position advance: ptr++ on every accept. If ptr==GENOME_LEN-1, then ptr<=0, dump_idx<=0 and state<=DUMP on the same edge.
- DUMP, outputs: gene_valid=1, gene_out=genome[dump_idx], gene_idx=dump_idx. These are combinational from registered state and must hold stable while gene_ready=0.
- DUMP, handshake:
  - on gene_valid && gene_ready, dump_idx++;
  - on the last index, state<=APPLY and gen_count++ (saturating).
- DUMP, in-flight trit: a trit arriving with trit_valid (issued one cycle before the state change) is captured in a 1-entry skid. The genome is not modified during DUMP.
- DUMP, skid overflow: a second arrival while the skid is full is dropped; err_count++ and err_flag is set.
- Skid drain: on return to APPLY the skid drains in the first cycle and applies to ptr=0 of the new generation. seq_enable stays 0 that cycle, so no collision with a new trit is possible.
- Pause: run=0 only gates seq_enable. Trits still arriving with trit_valid in APPLY are accepted.
- Counter rule: all counters saturate at 2^CNT_W-1 and do not wrap.

Decomposition:
- Shared package trinity_pkg holds:
  - trit_t (logic [1:0]);
  - constants TRIT_ZERO=2'b00, TRIT_POS=2'b01, TRIT_NEG=2'b10, TRIT_INV=2'b11;
  - function trit_sat_add(trit_t a, trit_t b);
  - state enum {APPLY, DUMP}.
- One natural sub-module: trinity_sat_counter (CNT_W-bit saturating incrementer), instantiated three times for gen_count, mut_count and err_count.

Test Plan:
- Reset check, GENOME_LEN=4: hold rst_n=0 for 3 cycles -> all outputs 0, seq_enable=0; with run=1 after release -> seq_enable=1 on the next cycle.
- One generation: trits +1,+1,-1,0 with gene_ready=1 -> DUMP emits idx0..3 = 01,01,10,00; gen_count=1, mut_count=3, then back to APPLY.
- Saturation: over two generations apply +1 then +1 at idx0, and -1 then +1 at idx1 -> second dump shows idx0=01, idx1=00.
- Invalid trit: inject 11 at idx2 -> gene unchanged, err_count=1, err_flag=1, ptr advances, mut_count not incremented.
- Skid and backpressure: assert trit_valid with +1 in the first DUMP cycle while holding gene_ready=0 for 5 cycles -> gene_idx and gene_out stable, no genome change. After the dump, the skid applies +1 to idx0 and seq_enable stays 0 for exactly 1 cycle.
- Mid-readout reset: pulse rst_n=0 at dump_idx=2 -> next cycle state is APPLY, genome all 00, gene_valid=0, counters 0.

Source files
------------

// File: rtl/trinity_pkg.sv
// Shared ternary types and helpers for the trinity genome mutator.
// Trit encoding: 00=0, 01=+1, 10=-1, 11=invalid.
package trinity_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b10;
    localparam trit_t TRIT_INV  = 2'b11;

    typedef enum logic {
        APPLY = 1'b0,
        DUMP  = 1'b1
    } state_t;

    // Clamped ternary sum; an invalid addend acts as zero.
    function automatic trit_t trit_sat_add(trit_t a, trit_t b);
        trit_t r;
        r = a;
        if (b == TRIT_POS) begin
            r = (a == TRIT_NEG) ? TRIT_ZERO : TRIT_POS;
        end else if (b == TRIT_NEG) begin
            r = (a == TRIT_POS) ? TRIT_ZERO : TRIT_NEG;
        end
        return r;
    endfunction

endpackage

// File: rtl/trinity_sat_counter.sv
// Saturating up-counter for the mutator statistics.
// Holds at all-ones instead of wrapping.
module trinity_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at the maximum value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/trinity_genome_mutator.sv
// Applies ternary mutations to a genome and streams it out
// after every full pass, stalling the sequencer meanwhile.
module trinity_genome_mutator
    import trinity_pkg::*;
#(
    parameter int GENOME_LEN = 16,
    parameter int IDX_W      = $clog2(GENOME_LEN),
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             seq_enable,
    input  logic             trit_valid,
    input  logic [1:0]       mutation_trit,
    output logic             gene_valid,
    input  logic             gene_ready,
    output logic [1:0]       gene_out,
    output logic [IDX_W-1:0] gene_idx,
    output logic [CNT_W-1:0] gen_count,
    output logic [CNT_W-1:0] mut_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_flag
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(GENOME_LEN - 1);

    state_t           state, state_n;
    trit_t            genome [GENOME_LEN];
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] dump_idx;
    logic             skid_valid;
    trit_t            skid_trit;

    logic             accept;
    trit_t            cur_trit;
    logic             dump_fire;
    logic             mut_inc;
    logic             err_inc;
    logic             gen_inc;

    // Outputs are forced idle while reset is asserted.
    always_comb begin
        seq_enable = rst_n && run && (state == APPLY) && !skid_valid;
        gene_valid = rst_n && (state == DUMP);
        gene_out   = gene_valid ? genome[dump_idx] : TRIT_ZERO;
        gene_idx   = gene_valid ? dump_idx : '0;
    end

    // Next state and per-cycle control; skid wins over a live trit.
    always_comb begin
        state_n   = state;
        accept    = 1'b0;
        cur_trit  = TRIT_ZERO;
        dump_fire = 1'b0;
        case (state)
            APPLY: begin
                accept   = skid_valid || trit_valid;
                cur_trit = skid_valid ? skid_trit : trit_t'(mutation_trit);
                if (accept && (ptr == LAST)) begin
                    state_n = DUMP;
                end
            end
            DUMP: begin
                dump_fire = gene_ready;
                if (gene_ready && (dump_idx == LAST)) begin
                    state_n = APPLY;
                end
            end
            default: state_n = APPLY;
        endcase
        mut_inc = accept && ((cur_trit == TRIT_POS) || (cur_trit == TRIT_NEG));
        err_inc = (accept && (cur_trit == TRIT_INV))
               || ((state == DUMP) && trit_valid && skid_valid);
        gen_inc = dump_fire && (dump_idx == LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= APPLY;
        end else begin
            state <= state_n;
        end
    end

    // Genome, pointers, skid entry and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < GENOME_LEN; i++) begin
                genome[i] <= TRIT_ZERO;
            end
            ptr        <= '0;
            dump_idx   <= '0;
            skid_valid <= 1'b0;
            skid_trit  <= TRIT_ZERO;
            err_flag   <= 1'b0;
        end else begin
            if (accept) begin
                genome[ptr] <= trit_sat_add(genome[ptr], cur_trit);
                if (ptr == LAST) begin
                    ptr      <= '0;
                    dump_idx <= '0;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            if ((state == APPLY) && skid_valid) begin
                skid_valid <= 1'b0;
            end
            if ((state == DUMP) && trit_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_trit  <= trit_t'(mutation_trit);
            end
            if (dump_fire) begin
                dump_idx <= (dump_idx == LAST) ? '0 : dump_idx + 1'b1;
            end
            if (err_inc) begin
                err_flag <= 1'b1;
            end
        end
    end

    trinity_sat_counter #(.CNT_W(CNT_W)) u_gen_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (gen_inc),
        .count (gen_count)
    );

    trinity_sat_counter #(.CNT_W(CNT_W)) u_mut_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mut_inc),
        .count (mut_count)
    );

    trinity_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .count (err_count)
    );

endmodule
